// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared CPU constants and types for the instruction-fetch front end.
package fetch_pc_ctrl_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;
  localparam logic [31:0] EXC_VECTOR   = 32'hbfc00380;
  // Each fetch bundle carries two 32-bit instructions.
  localparam logic [31:0] FETCH_STEP   = 32'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory request/response bus between fetch and the I-side memory.
interface fetch_pc_ctrl_if;

  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_addr_ok;
  logic        ireq_data_ok;
  logic [63:0] ireq_rdata;

  modport master (
    output ireq_valid, ireq_addr,
    input  ireq_addr_ok, ireq_data_ok, ireq_rdata
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output ireq_addr_ok, ireq_data_ok, ireq_rdata
  );

endinterface

// File: rtl/fetch_redirect_sel.sv
// Picks the winning redirect source and its target pc: cp0_flush > eret > bp_fail.
module fetch_redirect_sel
  import fetch_pc_ctrl_pkg::*;
(
  input  logic        cp0_flush,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        bp_fail,
  input  logic [31:0] bp_target,
  output logic        redirect,
  output logic [31:0] target
);

  always_comb begin
    redirect = 1'b1;
    target   = '0;
    if (cp0_flush)    target = EXC_VECTOR;
    else if (eret)    target = epc;
    else if (bp_fail) target = bp_target;
    else              redirect = 1'b0;
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch pc sequencer: one outstanding I-mem request at a time, registered bundle to decode.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   stall,
  input  logic                   cp0_flush,
  input  logic                   eret,
  input  logic [31:0]            epc,
  input  logic                   bp_fail,
  input  logic [31:0]            bp_target,
  fetch_pc_ctrl_if.master        imem,
  output logic                   fetch_valid,
  output logic [31:0]            fetch_pc,
  output logic [63:0]            fetch_data
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         discard;
  logic         redirect;
  logic [31:0]  target;

  fetch_redirect_sel u_sel (
    .cp0_flush (cp0_flush),
    .eret      (eret),
    .epc       (epc),
    .bp_fail   (bp_fail),
    .bp_target (bp_target),
    .redirect  (redirect),
    .target    (target)
  );

  assign imem.ireq_valid = (state == S_REQ);
  assign imem.ireq_addr  = pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      pc          <= RESET_VECTOR;
      req_pc      <= '0;
      discard     <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
      fetch_data  <= '0;
    end else begin
      if (redirect) pc <= target;
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (imem.ireq_addr_ok) begin
            state <= S_WAIT;
            // An accept alongside a redirect fetches the old path; its data must be dropped.
            discard <= redirect;
            if (!redirect) begin
              req_pc <= pc;
              pc     <= pc + FETCH_STEP;
            end
          end
        end
        S_WAIT: begin
          if (imem.ireq_data_ok) begin
            discard <= 1'b0;
            if (redirect || discard) begin
              state <= S_REQ;
            end else begin
              fetch_valid <= 1'b1;
              fetch_pc    <= req_pc;
              fetch_data  <= imem.ireq_rdata;
              state       <= S_HOLD;
            end
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || !stall) begin
            fetch_valid <= 1'b0;
            state       <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed + randomized bench for fetch_pc_ctrl against a transaction-level fetch model.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall, cp0_flush, eret, bp_fail;
  logic [31:0] epc, bp_target;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [63:0] fetch_data;

  fetch_pc_ctrl_if imem ();

  fetch_pc_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .stall      (stall),
    .cp0_flush  (cp0_flush),
    .eret       (eret),
    .epc        (epc),
    .bp_fail    (bp_fail),
    .bp_target  (bp_target),
    .imem       (imem),
    .fetch_valid(fetch_valid),
    .fetch_pc   (fetch_pc),
    .fetch_data (fetch_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: pc of the next request, at most one outstanding request (maybe stale), at most one held bundle.
  bit          m_run, m_out, m_stale, m_have;
  logic [31:0] m_pc, m_opc, m_fpc;
  logic [63:0] m_fdata;
  bit          pend;
  int          lat;

  task automatic m_reset();
    m_run = 0; m_out = 0; m_stale = 0; m_have = 0;
    m_pc = 32'hbfc00000; m_opc = 0; m_fpc = 0; m_fdata = 0;
  endtask

  task automatic m_step();
    bit          redir, want;
    logic [31:0] tgt, npc;
    redir = 1; tgt = 0;
    if (cp0_flush)    tgt = 32'hbfc00380;
    else if (eret)    tgt = epc;
    else if (bp_fail) tgt = bp_target;
    else              redir = 0;
    want = m_run && !m_out && !m_have;
    npc  = m_pc;
    if (redir) npc = tgt;
    else if (want && imem.ireq_addr_ok) npc = m_pc + 32'd8;
    if (!m_run) m_run = 1;
    else if (want && imem.ireq_addr_ok) begin
      m_out = 1; m_opc = m_pc; m_stale = redir;
    end else if (m_out && imem.ireq_data_ok) begin
      m_out = 0;
      if (!m_stale && !redir) begin
        m_have = 1; m_fpc = m_opc; m_fdata = imem.ireq_rdata;
      end
      m_stale = 0;
    end else if (m_out && redir) m_stale = 1;
    else if (m_have && (redir || !stall)) m_have = 0;
    m_pc = npc;
  endtask

  task automatic check_out();
    bit want;
    want = m_run && !m_out && !m_have;
    chk("ireq_valid", 64'(imem.ireq_valid), 64'(want));
    if (want) chk("ireq_addr", 64'(imem.ireq_addr), 64'(m_pc));
    chk("fetch_valid", 64'(fetch_valid), 64'(m_have));
    if (m_have) begin
      chk("fetch_pc", 64'(fetch_pc), 64'(m_fpc));
      chk("fetch_data", fetch_data, m_fdata);
    end
  endtask

  task automatic clr_in();
    stall = 0; cp0_flush = 0; eret = 0; bp_fail = 0; epc = 0; bp_target = 0;
    imem.ireq_addr_ok = 0; imem.ireq_data_ok = 0; imem.ireq_rdata = 0;
  endtask

  task automatic tick();
    bit acc;
    acc = imem.ireq_valid && imem.ireq_addr_ok;
    @(posedge clk);
    if (!resetn) begin
      m_reset(); pend = 0;
    end else begin
      m_step();
      if (acc) begin pend = 1; lat = $urandom_range(0, 3); end
      else if (imem.ireq_data_ok) pend = 0;
      else if (lat > 0) lat--;
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic do_reset();
    resetn = 0;
    clr_in();
    m_reset(); pend = 0; lat = 0;
    #1;
    chk("rst_ireq_valid", 64'(imem.ireq_valid), 64'd0);
    chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("rst_fetch_pc", 64'(fetch_pc), 64'd0);
    chk("rst_fetch_data", fetch_data, 64'd0);
    tick(); tick();
    resetn = 1;
  endtask

  initial begin
    resetn = 0;
    clr_in();
    m_reset(); pend = 0; lat = 0;
    @(negedge clk);
    do_reset();

    // Two sequential fetches from the reset vector.
    tick();
    chk("seq_addr0", 64'(imem.ireq_addr), 64'hbfc00000);
    imem.ireq_addr_ok = 1; tick();
    imem.ireq_addr_ok = 0; imem.ireq_data_ok = 1; imem.ireq_rdata = 64'h1111_2222_3333_4444; tick();
    chk("seq_fpc0", 64'(fetch_pc), 64'hbfc00000);
    imem.ireq_data_ok = 0; tick();
    chk("seq_addr1", 64'(imem.ireq_addr), 64'hbfc00008);

    // Stalled bundle stays put for five cycles.
    imem.ireq_addr_ok = 1; tick();
    imem.ireq_addr_ok = 0; imem.ireq_data_ok = 1; imem.ireq_rdata = 64'h5555_6666_7777_8888; tick();
    imem.ireq_data_ok = 0; stall = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_fpc", 64'(fetch_pc), 64'hbfc00008);
      chk("stall_fdata", fetch_data, 64'h5555_6666_7777_8888);
      chk("stall_noreq", 64'(imem.ireq_valid), 64'd0);
    end
    stall = 0; tick();
    chk("stall_next_addr", 64'(imem.ireq_addr), 64'hbfc00010);

    // Mispredict while waiting: the late data is dropped.
    imem.ireq_addr_ok = 1; tick();
    imem.ireq_addr_ok = 0; bp_fail = 1; bp_target = 32'h80001000; tick();
    bp_fail = 0; tick(); tick();
    imem.ireq_data_ok = 1; tick();
    imem.ireq_data_ok = 0;
    chk("bp_no_fetch", 64'(fetch_valid), 64'd0);
    chk("bp_addr", 64'(imem.ireq_addr), 64'h80001000);

    // All three redirects together: exception wins.
    cp0_flush = 1; eret = 1; epc = 32'h80002000; bp_fail = 1; bp_target = 32'h80003000; tick();
    cp0_flush = 0; eret = 0; bp_fail = 0;
    chk("prio_addr", 64'(imem.ireq_addr), 64'hbfc00380);

    // pc wraps past the top of the address space.
    bp_fail = 1; bp_target = 32'hfffffff8; tick();
    bp_fail = 0; imem.ireq_addr_ok = 1; tick();
    imem.ireq_addr_ok = 0; imem.ireq_data_ok = 1; imem.ireq_rdata = 64'hdead_beef_cafe_f00d; tick();
    chk("wrap_fpc", 64'(fetch_pc), 64'hfffffff8);
    imem.ireq_data_ok = 0; tick();
    chk("wrap_addr", 64'(imem.ireq_addr), 64'h0);

    // Reset mid-request; a stray data_ok afterwards is ignored.
    imem.ireq_addr_ok = 1; tick();
    do_reset();
    imem.ireq_data_ok = 1; imem.ireq_rdata = 64'hbad0_bad0_bad0_bad0; tick(); tick();
    imem.ireq_data_ok = 0;
    chk("rst_stray_fvld", 64'(fetch_valid), 64'd0);
    chk("rst_first_addr", 64'(imem.ireq_addr), 64'hbfc00000);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        continue;
      end
      stall     = ($urandom_range(0, 9) < 4);
      cp0_flush = ($urandom_range(0, 39) == 0);
      eret      = ($urandom_range(0, 29) == 0);
      bp_fail   = ($urandom_range(0, 14) == 0);
      epc       = $urandom & 32'hfffffff8;
      bp_target = $urandom & 32'hfffffff8;
      imem.ireq_addr_ok = imem.ireq_valid && ($urandom_range(0, 3) != 0);
      imem.ireq_data_ok = pend ? (lat == 0 && $urandom_range(0, 2) != 0)
                               : ($urandom_range(0, 24) == 0);
      imem.ireq_rdata   = {$urandom, $urandom};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
